// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The tag states exist only when UART_ARB_TAG_EN is defined.
package uart_pkg;

   localparam logic [3:0] TAG_NIBBLE   = 4'hA;
   localparam int         BUSY_TIMEOUT = 4;

   typedef enum logic [2:0] {
      S_IDLE          = 3'd0,
      S_ISSUE         = 3'd1,
      S_WAIT_BUSY     = 3'd2,
      S_WAIT_DONE     = 3'd3
`ifdef UART_ARB_TAG_EN
      ,
      S_TAG_ISSUE     = 3'd4,
      S_TAG_WAIT_BUSY = 3'd5,
      S_TAG_WAIT_DONE = 3'd6
`endif
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past the last grant and wraps.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_grant,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_any
);

   logic [IDX_W-1:0] w_pos;

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      w_pos       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_pos = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
         if (!o_any && i_req[w_pos]) begin
            o_any          = 1'b1;
            o_grant[w_pos] = 1'b1;
            o_grant_idx    = w_pos;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_TAG_EN to prefix every byte with a {4'hA, grant_id} tag frame.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [NUM_REQ-1:0]              i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]              o_req_ready,
   output logic                            o_tx_valid,
   output logic [DATA_WIDTH-1:0]           o_tx_data_in,
   input  logic                            i_tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]      o_grant_id,
   output logic                            o_arb_busy,
   output logic [2:0]                      o_state
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t             r_state;
   arb_state_t             w_next;
   logic [DATA_WIDTH-1:0]  r_hold;
   logic [IDX_W-1:0]       r_last_grant;
   logic [IDX_W-1:0]       r_grant_id;
   logic [2:0]             r_timer;
   logic                   w_timer_inc;
   logic [NUM_REQ-1:0]     w_grant;
   logic [IDX_W-1:0]       w_grant_idx;
   logic                   w_any;
   logic                   w_accept;
`ifdef UART_ARB_TAG_EN
   logic [7:0]             w_tag_byte;
   assign w_tag_byte = {TAG_NIBBLE, 4'(r_grant_id)};
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .i_req        (i_req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_grant_idx  (w_grant_idx),
      .o_any        (w_any)
   );

   // A foreign user holding tx_busy in IDLE blocks acceptance.
   assign w_accept = (r_state == S_IDLE) && w_any && !i_tx_busy && !i_rst;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_hold       <= '0;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_grant_id   <= '0;
         r_timer      <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_hold       <= i_req_data[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_last_grant <= w_grant_idx;
            r_grant_id   <= w_grant_idx;
         end
         if (w_timer_inc) r_timer <= r_timer + 3'd1;
         else             r_timer <= '0;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_timer_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
`ifdef UART_ARB_TAG_EN
               w_next = S_TAG_ISSUE;
`else
               w_next = S_ISSUE;
`endif
            end
         end
         S_ISSUE: w_next = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (i_tx_busy)                                w_next = S_WAIT_DONE;
            else if (r_timer == 3'(BUSY_TIMEOUT - 1))     w_next = S_ISSUE;
            else                                          w_timer_inc = 1'b1;
         end
         S_WAIT_DONE: if (!i_tx_busy) w_next = S_IDLE;
`ifdef UART_ARB_TAG_EN
         S_TAG_ISSUE: w_next = S_TAG_WAIT_BUSY;
         S_TAG_WAIT_BUSY: begin
            if (i_tx_busy)                                w_next = S_TAG_WAIT_DONE;
            else if (r_timer == 3'(BUSY_TIMEOUT - 1))     w_next = S_TAG_ISSUE;
            else                                          w_timer_inc = 1'b1;
         end
         S_TAG_WAIT_DONE: if (!i_tx_busy) w_next = S_ISSUE;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_req_ready  = w_accept ? w_grant : '0;
      o_tx_valid   = (r_state == S_ISSUE);
      o_tx_data_in = r_hold;
`ifdef UART_ARB_TAG_EN
      if (r_state == S_TAG_ISSUE) o_tx_valid = 1'b1;
      if (r_state == S_TAG_ISSUE || r_state == S_TAG_WAIT_BUSY || r_state == S_TAG_WAIT_DONE)
         o_tx_data_in = DATA_WIDTH'(w_tag_byte);
`endif
   end

   assign o_grant_id = r_grant_id;
   assign o_arb_busy = (r_state != S_IDLE);
   assign o_state    = r_state;

endmodule
